// File: rtl/one_hot_decode_stage.sv
// rtl/one_hot_decode_stage.sv - registered one-hot to binary decode stage with saturating error count
module one_hot_decode_stage #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ONE_HOT_W-1:0] in_one_hot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     out_bin,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0]       dec_bin;
  logic                   dec_err;
  logic                   accept;
  logic                   xfer;

  assign out_valid = (state_q == FULL);
  assign out_bin   = bin_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

  // Ready whenever the register is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Decode: index of the lowest set bit; illegal if zero or more than one bit set.
  always_comb begin
    dec_bin = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      if (in_one_hot[i]) begin
        dec_bin = BIN_W'(i);
      end
    end
    dec_err = (in_one_hot == '0) ||
              ((in_one_hot & (in_one_hot - ONE_HOT_W'(1))) != '0);
  end

  // Control state and output register next values.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer && !accept) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      bin_d = dec_bin;
      err_d = dec_err;
    end
  end

  // Error counter: clear first, then count an illegal accept, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end
    if (accept && dec_err && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset that discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      bin_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_one_hot_decode_stage.sv
// tb/tb_one_hot_decode_stage.sv - randomized self-checking bench for one_hot_decode_stage
module tb_one_hot_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_one_hot;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bin;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [3:0] bin;
    logic       err;
  } res_t;

  res_t   exp_q[$];
  int     exp_cnt;
  int     n_checks;
  int     n_fail;

  one_hot_decode_stage #(
    .BIN_W(4),
    .ONE_HOT_W(16),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_one_hot(in_one_hot),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin(out_bin),
    .out_err(out_err),
    .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int ref_low_idx(input logic [15:0] x);
    logic [15:0] lsb;
    lsb = x & (~x + 16'd1);
    if (x == 16'd0) return 0;
    return $clog2(lsb);
  endfunction

  function automatic logic ref_illegal(input logic [15:0] x);
    return $countones(x) != 1;
  endfunction

  // One cycle: drive at negedge, check ready, advance model at posedge, check outputs at next negedge.
  task automatic step(input logic v, input logic [15:0] oh, input logic ordy, input logic clr);
    logic exp_rdy;
    logic acc;
    logic xf;
    res_t r;
    in_valid   = v;
    in_one_hot = oh;
    out_ready  = ordy;
    err_clr    = clr;
    exp_rdy    = (exp_q.size() == 0) || ordy;
    #1;
    check_eq("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    xf  = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (xf) void'(exp_q.pop_front());
    if (clr) exp_cnt = 0;
    if (acc) begin
      r.bin = 4'(ref_low_idx(oh));
      r.err = ref_illegal(oh);
      exp_q.push_back(r);
      if (r.err && exp_cnt < 255) exp_cnt++;
    end
    @(negedge clk);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("out_bin", out_bin, exp_q[0].bin);
      check_eq("out_err", out_err, exp_q[0].err);
    end
    check_eq("err_cnt", err_cnt, exp_cnt);
  endtask

  initial begin
    logic [15:0] oh;
    n_checks   = 0;
    n_fail     = 0;
    exp_cnt    = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_one_hot = 16'd0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_bin", out_bin, 4'd0);
    check_eq("rst_out_err", out_err, 1'b0);
    check_eq("rst_err_cnt", err_cnt, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", in_ready, 1'b1);

    // Legal sweep.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'd1 << i, 1'b1, 1'b0);
      check_eq("sweep_bin", out_bin, i);
      check_eq("sweep_err", out_err, 1'b0);
      check_eq("sweep_valid", out_valid, 1'b1);
    end
    check_eq("sweep_cnt", err_cnt, 8'd0);

    // Illegal codes.
    step(1'b1, 16'h0000, 1'b1, 1'b0);
    check_eq("zero_bin", out_bin, 4'd0);
    check_eq("zero_err", out_err, 1'b1);
    step(1'b1, 16'h0028, 1'b1, 1'b0);
    check_eq("multi_bin", out_bin, 4'd3);
    check_eq("multi_err", out_err, 1'b1);
    check_eq("illegal_cnt", err_cnt, 8'd2);

    // Backpressure.
    step(1'b1, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h0004, 1'b0, 1'b0);
      check_eq("bp_hold_bin", out_bin, 4'd8);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    step(1'b1, 16'h0004, 1'b1, 1'b0);
    check_eq("bp_next_bin", out_bin, 4'd2);
    step(1'b0, 16'hFFFF, 1'b1, 1'b0);
    check_eq("bp_drain_valid", out_valid, 1'b0);

    // Saturation and clear.
    for (int i = 0; i < 260; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
    check_eq("sat_cnt", err_cnt, 8'd255);
    step(1'b1, 16'h0000, 1'b1, 1'b1);
    check_eq("clr_with_err", err_cnt, 8'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("clr_alone", err_cnt, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0, 3: oh = 16'd1 << $urandom_range(0, 15);
        1:    oh = 16'd0;
        default: oh = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 3) != 0), oh, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0));
    end

    // Reset mid-operation with a held result and err_cnt=5.
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 16'h0040, 1'b0, 1'b0);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    check_eq("pre_rst_cnt", err_cnt, 8'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", out_valid, 1'b0);
    check_eq("async_bin", out_bin, 4'd0);
    check_eq("async_err", out_err, 1'b0);
    check_eq("async_cnt", err_cnt, 8'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 16'h0080, 1'b1, 1'b0);
    check_eq("post_rst_bin", out_bin, 4'd7);
    check_eq("post_rst_err", out_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
